// File: rtl/multi_wait_counter.sv
// Multi-channel programmable wait counter: per-channel periodic or one-shot tick generation on CLK_50M.
// Latency: flag asserts top+2 edges after enable is sampled high in IDLE, then every top+1 edges (periodic).
// No backpressure: flags are single-cycle pulses unless TICK_STICKY_EN makes them sticky until ack.
module multi_wait_counter #(
    parameter int WIDTH = 32,
    parameter int N_CH  = 2
) (
    input  logic                    CLK_50M,
    input  logic                    reset,
    input  logic [N_CH-1:0]         enable,
    input  logic [N_CH-1:0]         oneshot,
    input  logic [N_CH*WIDTH-1:0]   top_count,
    input  logic [N_CH-1:0]         ack,
    output logic [N_CH-1:0]         flag,
    output logic [N_CH-1:0]         busy,
    output logic [N_CH-1:0]         overrun
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

`ifndef TICK_STICKY_EN
    // Acknowledge only matters for sticky flags; keep it visibly consumed here.
    logic ack_unused;
    assign ack_unused = |ack;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t            state;
        logic [WIDTH-1:0]  count;
        logic [WIDTH-1:0]  top_q;
        logic [WIDTH-1:0]  top_slice;
        logic              tick;
        logic              busy_q;
        logic              flag_q;
        logic              overrun_q;

        assign top_slice  = top_count[i*WIDTH +: WIDTH];
        assign flag[i]    = flag_q;
        assign busy[i]    = busy_q;
        assign overrun[i] = overrun_q;

        // Channel state machine: counts up to the latched limit and raises tick on the match edge.
        always_ff @(posedge CLK_50M or posedge reset) begin
            if (reset) begin
                state  <= S_IDLE;
                count  <= '0;
                top_q  <= '0;
                tick   <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        count <= '0;
                        tick  <= 1'b0;
                        if (enable[i]) begin
                            state  <= S_RUN;
                            top_q  <= top_slice;
                            busy_q <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (!enable[i]) begin
                            state  <= S_IDLE;
                            count  <= '0;
                            tick   <= 1'b0;
                            busy_q <= 1'b0;
                        end else if (count == top_q) begin
                            // Match is checked before increment, so an all-ones limit never overflows.
                            count <= '0;
                            tick  <= 1'b1;
                            if (oneshot[i]) begin
                                state  <= S_DONE;
                                busy_q <= 1'b0;
                            end else begin
                                top_q <= top_slice;
                            end
                        end else begin
                            count <= count + ONE;
                            tick  <= 1'b0;
                        end
                    end
                    S_DONE: begin
                        count <= '0;
                        tick  <= 1'b0;
                        // Re-trigger needs enable low for at least one edge.
                        if (!enable[i]) begin
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        state  <= S_IDLE;
                        count  <= '0;
                        tick   <= 1'b0;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end

`ifdef TICK_STICKY_EN
        // Sticky flag: set by tick, cleared by ack; tick wins a same-cycle collision. Overrun flags a missed ack.
        always_ff @(posedge CLK_50M or posedge reset) begin
            if (reset) begin
                flag_q    <= 1'b0;
                overrun_q <= 1'b0;
            end else begin
                if (tick) begin
                    flag_q <= 1'b1;
                end else if (ack[i]) begin
                    flag_q <= 1'b0;
                end
                if (tick && flag_q && !ack[i]) begin
                    overrun_q <= 1'b1;
                end else if (ack[i]) begin
                    overrun_q <= 1'b0;
                end
            end
        end
`else
        // Pulse flag: one-cycle registered copy of tick, so a pending tick survives enable dropping.
        always_ff @(posedge CLK_50M or posedge reset) begin
            if (reset) begin
                flag_q <= 1'b0;
            end else begin
                flag_q <= tick;
            end
        end

        assign overrun_q = 1'b0;
`endif
    end

endmodule

// File: tb/tb_multi_wait_counter.sv
module tb_multi_wait_counter;

    localparam int WIDTH = 8;
    localparam int N_CH  = 2;
    localparam int MAXK  = 600;

    logic                  CLK_50M;
    logic                  reset;
    logic [N_CH-1:0]       enable;
    logic [N_CH-1:0]       oneshot;
    logic [N_CH*WIDTH-1:0] top_count;
    logic [N_CH-1:0]       ack;
    logic [N_CH-1:0]       flag;
    logic [N_CH-1:0]       busy;
    logic [N_CH-1:0]       overrun;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string           tag;
        int              k;
        logic [N_CH-1:0] f;
        logic [N_CH-1:0] b;
        logic [N_CH-1:0] o;
    } exp_t;

    exp_t sbq[$];

    // Expected timeline per channel, indexed by edge number after the start edge E0.
    logic ef [N_CH][MAXK];
    logic eb [N_CH][MAXK];
    logic eo [N_CH][MAXK];

    multi_wait_counter #(
        .WIDTH (WIDTH),
        .N_CH  (N_CH)
    ) dut (
        .CLK_50M   (CLK_50M),
        .reset     (reset),
        .enable    (enable),
        .oneshot   (oneshot),
        .top_count (top_count),
        .ack       (ack),
        .flag      (flag),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial begin
        CLK_50M = 1'b0;
        forever #10 CLK_50M = ~CLK_50M;
    end

    task automatic clear_exp();
        for (int c = 0; c < N_CH; c++) begin
            for (int k = 0; k < MAXK; k++) begin
                ef[c][k] = 1'b0;
                eb[c][k] = 1'b0;
                eo[c][k] = 1'b0;
            end
        end
    endtask

    // Flags at first, first+period, ... up to last (period 0 = single flag).
    task automatic set_flags(input int c, input int first, input int period, input int last);
        if (period == 0) begin
            ef[c][first] = 1'b1;
        end else begin
            for (int k = first; k <= last; k += period) ef[c][k] = 1'b1;
        end
    endtask

    task automatic set_busy(input int c, input int from, input int to);
        for (int k = from; k <= to; k++) eb[c][k] = 1'b1;
    endtask

    task automatic set_ovr(input int c, input int from, input int to);
        for (int k = from; k <= to; k++) eo[c][k] = 1'b1;
    endtask

    task automatic set_top(input int c, input int v);
        top_count[c*WIDTH +: WIDTH] = v[WIDTH-1:0];
    endtask

    task automatic push_range(input string tag, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.tag = tag;
            e.k   = k;
            for (int c = 0; c < N_CH; c++) begin
                e.f[c] = ef[c][k];
                e.b[c] = eb[c][k];
                e.o[c] = eo[c][k];
            end
            sbq.push_back(e);
        end
    endtask

    // Advance m edges, sampling 1 time unit after each rising edge and comparing with the scoreboard.
    task automatic run_cycles(input int m);
        exp_t e;
        for (int i = 0; i < m; i++) begin
            @(posedge CLK_50M);
            #1;
            checks++;
            assert (sbq.size() != 0) else begin
                errors++;
                $error("FAIL scoreboard_empty got size %0d want nonzero", sbq.size());
            end
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                checks++;
                assert (flag === e.f) else begin
                    errors++;
                    $error("FAIL %s k=%0d flag got %b want %b", e.tag, e.k, flag, e.f);
                end
                checks++;
                assert (busy === e.b) else begin
                    errors++;
                    $error("FAIL %s k=%0d busy got %b want %b", e.tag, e.k, busy, e.b);
                end
                checks++;
                assert (overrun === e.o) else begin
                    errors++;
                    $error("FAIL %s k=%0d overrun got %b want %b", e.tag, e.k, overrun, e.o);
                end
            end
        end
    endtask

    // Assert reset between edges, check outputs clear at once, hold across one edge, release.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        checks++;
        assert (flag === '0) else begin
            errors++;
            $error("FAIL %s reset flag got %b want 00", tag, flag);
        end
        checks++;
        assert (busy === '0) else begin
            errors++;
            $error("FAIL %s reset busy got %b want 00", tag, busy);
        end
        checks++;
        assert (overrun === '0) else begin
            errors++;
            $error("FAIL %s reset overrun got %b want 00", tag, overrun);
        end
        @(posedge CLK_50M);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        enable    = '0;
        oneshot   = '0;
        top_count = '0;
        ack       = '0;
        #3;
        do_reset("init");

`ifdef TICK_STICKY_EN
        // Sticky flag, top=2: ticks set at E3, E6, E9, E12.
        clear_exp();
        set_flags(0, 4, 1, 10);
        set_flags(0, 13, 0, 13);
        set_busy(0, 0, 13);
        set_ovr(0, 7, 9);
        push_range("sticky", 14);
        set_top(0, 2);
        enable = 2'b01;
        run_cycles(10);
        ack = 2'b01;
        run_cycles(2);
        ack = 2'b00;
        run_cycles(2);
        enable = '0;
        do_reset("sticky_end");
`else
        // Periodic: ch0 top=4, ch1 top=0; ack held high must have no effect.
        clear_exp();
        set_flags(0, 6, 5, 19);
        set_busy(0, 0, 19);
        set_flags(1, 2, 1, 19);
        set_busy(1, 0, 19);
        push_range("periodic", 20);
        set_top(0, 4);
        set_top(1, 0);
        ack    = 2'b11;
        enable = 2'b11;
        run_cycles(20);
        enable = '0;
        ack    = '0;
        do_reset("periodic_end");

        // One-shot top=3, held enable gives one flag; re-trigger after enable low.
        clear_exp();
        set_flags(0, 5, 0, 5);
        set_busy(0, 0, 3);
        set_flags(0, 15, 0, 15);
        set_busy(0, 10, 13);
        push_range("oneshot", 20);
        set_top(0, 3);
        oneshot = 2'b01;
        enable  = 2'b01;
        run_cycles(8);
        enable = '0;
        run_cycles(2);
        enable = 2'b01;
        run_cycles(10);
        enable  = '0;
        oneshot = '0;
        do_reset("oneshot_end");

        // Limit change 4->9 at count=2 on ch0 while ch1 runs top=2.
        clear_exp();
        set_flags(0, 6, 0, 6);
        set_flags(0, 16, 10, 29);
        set_busy(0, 0, 29);
        set_flags(1, 4, 3, 29);
        set_busy(1, 0, 29);
        push_range("limit", 30);
        set_top(0, 4);
        set_top(1, 2);
        enable = 2'b11;
        run_cycles(3);
        set_top(0, 9);
        run_cycles(27);
        enable = '0;
        do_reset("limit_end");

        // Enable dropped at count=3 with top=6: no flag, busy falls next edge.
        clear_exp();
        set_busy(0, 0, 3);
        push_range("drop_mid", 10);
        set_top(0, 6);
        enable = 2'b01;
        run_cycles(4);
        enable = '0;
        run_cycles(6);
        do_reset("drop_mid_end");

        // Enable dropped in the cycle tick is set: that flag still appears.
        clear_exp();
        set_flags(0, 8, 0, 8);
        set_busy(0, 0, 7);
        push_range("drop_tick", 12);
        set_top(0, 6);
        enable = 2'b01;
        run_cycles(8);
        enable = '0;
        run_cycles(4);
        do_reset("drop_tick_end");

        // Reset at count=5 with top=10, enable kept high; restart gives flag 12 edges later.
        clear_exp();
        set_busy(0, 0, 5);
        push_range("pre_reset", 6);
        set_top(0, 10);
        enable = 2'b01;
        run_cycles(6);
        do_reset("reset_mid");
        clear_exp();
        set_flags(0, 12, 0, 12);
        set_busy(0, 0, 14);
        push_range("post_reset", 15);
        run_cycles(15);
        enable = '0;
        do_reset("reset_mid_end");

        // Oneshot raised mid-count in a periodic run: applies at the next match.
        clear_exp();
        set_flags(0, 5, 0, 5);
        set_busy(0, 0, 3);
        push_range("oneshot_mid", 12);
        set_top(0, 3);
        enable = 2'b01;
        run_cycles(3);
        oneshot = 2'b01;
        run_cycles(9);
        enable  = '0;
        oneshot = '0;
        do_reset("oneshot_mid_end");

        // All-ones limit: period 2^WIDTH with no overflow; ch1 top=1 alongside.
        clear_exp();
        set_flags(0, 257, 256, 519);
        set_busy(0, 0, 519);
        set_flags(1, 3, 2, 519);
        set_busy(1, 0, 519);
        push_range("max_top", 520);
        set_top(0, 255);
        set_top(1, 1);
        enable = 2'b11;
        run_cycles(520);
        enable = '0;
        do_reset("max_top_end");
`endif

        checks++;
        assert (sbq.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_leftover got %0d want 0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_wait_counter.md
# multi_wait_counter

Parametrised, multi-channel successor to the single-channel sample-rate wait counter. Each channel counts CLK_50M cycles up to its own programmable limit and emits a one-cycle flag, either periodically (sample-rate pacing for audio playback) or once (one-shot delays for flash/handshake timeouts). It sits between the playback/flash-read state machines and the audio path, so several independent timing sources can run from one instance.

## Interface
- WIDTH, 32, counter and limit width per channel
- N_CH, 2, number of independent channels (1..8)
- CLK_50M  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- enable  input  N_CH  per-channel run request; low forces channel idle
- oneshot  input  N_CH  per-channel mode: 0 = periodic, 1 = one-shot
- top_count  input  N_CH*WIDTH  per-channel limit; channel i uses bits [i*WIDTH +: WIDTH]
- ack  input  N_CH  per-channel flag acknowledge (used only with TICK_STICKY_EN)
- flag  output  N_CH  per-channel tick output (registered)
- busy  output  N_CH  high while channel is in RUN
- overrun  output  N_CH  missed-acknowledge indicator (used only with TICK_STICKY_EN)

## Operation
- Per channel: WIDTH-bit count, latched limit top_q, internal tick register, state machine IDLE / RUN / DONE.
- Reset: count=0, top_q=0, tick=0, state=IDLE; flag, busy, overrun all 0. Asynchronous, takes effect mid-count; operation restarts from IDLE after release.
- IDLE: count=0, tick=0. If enable=1 at an edge: state->RUN, count<=0, top_q<=top_count slice.
- RUN: if enable=0 -> IDLE, count<=0, tick<=0. Else if count==top_q: count<=0, tick<=1; periodic -> stay RUN and re-latch top_q from top_count; one-shot -> DONE. Else count<=count+1, tick<=0.
- DONE: tick=0, count held 0; remains until enable=0, then IDLE. Re-trigger requires enable low for at least one edge.
- top_count changes during RUN take effect only at the next wrap (periodic) or next start.
- oneshot is sampled every cycle in RUN; change mid-count applies at the next match.
- Arithmetic unsigned, WIDTH bits; top_count=0 gives a tick every cycle; top_count=2^WIDTH-1 gives a period of 2^WIDTH cycles with no overflow (match occurs before wrap).
- flag <= tick each edge (default build). A tick already in the tick register when enable drops still appears on flag one cycle later.
- busy = (state==RUN), registered with the state.
- Channels fully independent; no shared state.

## Timing
- Edge E0: enable sampled high in IDLE. count=k after edge Ek. tick set at edge E(top+1). flag high for exactly one cycle after edge E(top+2).
- Periodic: subsequent flags every top+1 cycles, pulse width 1 cycle (continuous high only when top=0).
- One-shot: exactly one flag per enable assertion.
- busy rises after E0 and falls after the matching edge (one-shot) or the edge sampling enable=0.

## Configuration
- TICK_STICKY_EN defined: flag is a sticky per-channel bit. Set when tick=1, cleared at an edge with ack=1 and tick=0. If tick and ack occur in the same cycle, flag stays 1. overrun set at an edge with tick=1, flag already 1 and ack=0; cleared by ack. enable low does not clear flag; reset does.
- TICK_STICKY_EN undefined: flag is the one-cycle pulse described above, ack ignored, overrun tied 0.

## Test plan
- Reset mid-count: N_CH=2, top=10, assert reset at count=5 -> flag, busy, overrun 0 immediately; after release with enable still high, first flag 12 edges later.
- Periodic: top=4, enable held -> first flag after E6, then every 5 cycles, each 1 cycle wide; top=0 -> flag high every cycle from E2.
- One-shot: oneshot=1, top=3 -> single flag after E5, busy low after E4; no further flags until enable drops and rises again.
- Limit change: periodic top=4, change to top=9 at count=2 -> current period stays 5, following periods 10; both channels with different limits run independently.
- Enable drop: top=6, drop enable at count=3 -> no flag, busy low next cycle; drop in the cycle tick is set -> that single flag still appears.
- TICK_STICKY_EN: top=2, no ack -> flag stays 1, overrun set at second tick; ack same cycle as tick -> flag remains 1, overrun clears.
